serial_adder: RTL and testbench

//   Parametrised bit-serial adder: adds two WIDTH-bit operands plus carry-in,
//   one bit per clock, LSB first, through a single registered full-adder cell.

---
 rtl/serial_adder.sv | 134 +++++++++++++
 tb/tb_serial_adder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built around one registered full-adder cell.
// The two operands are shifted out LSB first, one bit per clock, and the sum
// bits are shifted into a partial-sum register from the top. The published
// result (sum/cout/ovf) is updated once, on the edge that processes the MSB,
// and then held until the next operation completes.
module serial_adder #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    bit_cnt;

    logic             bit_sum;
    logic             bit_carry;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] psum_next;

    // Full-adder cell and step decode: the current LSBs plus the carry register
    // produce this cycle's sum bit and the carry into the next bit position.
    always_comb begin
        bit_sum   = a_sh[0] ^ b_sh[0] ^ carry;
        bit_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        last_bit  = (bit_cnt == LAST_BIT);
        accept    = (state == ST_IDLE) && start;
        psum_next = {bit_sum, psum[WIDTH-1:1]};
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs: busy covers RUN and DONE, done is the
    // single DONE cycle that follows the MSB step.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand shift registers, carry and bit counter: loaded on an accepted
    // start, advanced one bit per clock while running, untouched otherwise so
    // later changes on a/b/cin cannot disturb the operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            psum    <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            psum    <= '0;
            carry   <= cin;
            bit_cnt <= '0;
        end else if (state == ST_RUN) begin
            a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
            psum    <= psum_next;
            carry   <= bit_carry;
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Published result: captured only on the MSB step. The carry register still
    // holds the carry into the MSB at that point, which gives signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if ((state == ST_RUN) && last_bit) begin
            sum  <= psum_next;
            cout <= bit_carry;
            ovf  <= SIGNED ? (carry ^ bit_carry) : bit_carry;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: drives two 8-bit serial adders (unsigned and signed overflow
// mode) from the same stimulus. A reference model computes each result with
// plain arithmetic when an operation is accepted and queues it; a monitor
// compares the queued result against the outputs when done is due.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;

    logic         busy_u, done_u, cout_u, ovf_u;
    logic         busy_s, done_s, cout_s, ovf_s;
    logic [W-1:0] sum_u, sum_s;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf_u;
        logic         ovf_s;
        int           done_cyc;
    } exp_t;

    exp_t         sbq[$];

    int           cyc = 0;
    int           free_at = 0;
    int           busy_until = -1;
    int           n_ops = 0;
    int           checks = 0;
    int           errors = 0;

    logic [W-1:0] held_sum = '0;
    logic         held_cout = 1'b0;
    logic         held_ovf_u = 1'b0;
    logic         held_ovf_s = 1'b0;

    serial_adder #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy_u), .done(done_u), .sum(sum_u), .cout(cout_u), .ovf(ovf_u)
    );

    serial_adder #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy_s), .done(done_s), .sum(sum_s), .cout(cout_s), .ovf(ovf_s)
    );

    // Free-running clock and edge counter used to time expected events.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Drives one cycle of inputs on the falling edge and, if the adder is free
    // at the coming rising edge, queues the result the model predicts.
    task automatic applyStimulus(input logic st, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic ci);
        logic [W:0] full;
        int         ssum;
        int         e0;
        exp_t       e;
        @(negedge clk);
        start = st;
        a     = aa;
        b     = bb;
        cin   = ci;
        e0    = cyc + 1;
        if (st && rst_n && e0 >= free_at) begin
            full       = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ci};
            ssum       = int'($signed(aa)) + int'($signed(bb)) + int'(ci);
            e.sum      = full[W-1:0];
            e.cout     = full[W];
            e.ovf_u    = full[W];
            e.ovf_s    = (ssum > 127) || (ssum < -128);
            e.done_cyc = e0 + W;
            sbq.push_back(e);
            free_at    = e0 + W + 2;
            busy_until = e0 + W;
            n_ops++;
        end
    endtask

    // One accepted operation followed by idle cycles carrying junk operands.
    task automatic runOp(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ci);
        applyStimulus(1'b1, aa, bb, ci);
        repeat (W + 2) applyStimulus(1'b0, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    // Asynchronous reset: outputs must clear immediately, pending work is lost.
    task automatic doReset(input int hold);
        @(negedge clk);
        start      = 1'b0;
        rst_n      = 1'b0;
        sbq.delete();
        busy_until = -1;
        free_at    = 0;
        held_sum   = '0;
        held_cout  = 1'b0;
        held_ovf_u = 1'b0;
        held_ovf_s = 1'b0;
        #1;
        checkOutput("rst_busy", {30'd0, busy_u, busy_s}, 32'd0);
        checkOutput("rst_done", {30'd0, done_u, done_s}, 32'd0);
        checkOutput("rst_sum", {16'd0, sum_u, sum_s}, 32'd0);
        checkOutput("rst_flags", {28'd0, cout_u, ovf_u, cout_s, ovf_s}, 32'd0);
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: shortly after every rising edge compare handshake and result
    // outputs of both adders against the scoreboard and the held result.
    always @(posedge clk) begin
        logic exp_done;
        exp_t e;
        #2;
        exp_done = (sbq.size() > 0) && (sbq[0].done_cyc == cyc);
        checkOutput("done_u", {31'd0, done_u}, {31'd0, exp_done});
        checkOutput("done_s", {31'd0, done_s}, {31'd0, exp_done});
        checkOutput("busy_u", {31'd0, busy_u}, {31'd0, cyc <= busy_until});
        checkOutput("busy_s", {31'd0, busy_s}, {31'd0, cyc <= busy_until});
        if (exp_done) begin
            e          = sbq.pop_front();
            held_sum   = e.sum;
            held_cout  = e.cout;
            held_ovf_u = e.ovf_u;
            held_ovf_s = e.ovf_s;
        end
        checkOutput("sum_u", {24'd0, sum_u}, {24'd0, held_sum});
        checkOutput("sum_s", {24'd0, sum_s}, {24'd0, held_sum});
        checkOutput("cout_u", {31'd0, cout_u}, {31'd0, held_cout});
        checkOutput("cout_s", {31'd0, cout_s}, {31'd0, held_cout});
        checkOutput("ovf_u", {31'd0, ovf_u}, {31'd0, held_ovf_u});
        checkOutput("ovf_s", {31'd0, ovf_s}, {31'd0, held_ovf_s});
    end

    // Stimulus sequence: directed corner cases, back-to-back starts, reset in
    // the middle of an operation, then a long randomized run.
    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) applyStimulus(1'b0, '0, '0, 1'b0);

        $display("[TB] directed corner cases");
        runOp(8'hFF, 8'h01, 1'b0);
        runOp(8'h7F, 8'h01, 1'b0);
        runOp(8'h80, 8'hFF, 1'b0);
        runOp(8'hFF, 8'h01, 1'b0);
        runOp(8'h00, 8'h00, 1'b1);
        runOp(8'hFF, 8'hFF, 1'b1);
        runOp(8'h80, 8'h80, 1'b0);
        runOp(8'h7F, 8'h00, 1'b1);

        $display("[TB] start held high with changing operands");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b1, W'($urandom), W'($urandom), 1'($urandom));
        end
        repeat (W + 3) applyStimulus(1'b0, '0, '0, 1'b0);

        $display("[TB] reset during bit 3");
        applyStimulus(1'b1, 8'h55, 8'hAA, 1'b0);
        repeat (3) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        doReset(2);
        applyStimulus(1'b0, '0, '0, 1'b0);
        runOp(8'h55, 8'hAA, 1'b1);

        $display("[TB] randomized operations");
        for (int i = 0; i < 12000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 1'($urandom));
        end
        repeat (W + 4) applyStimulus(1'b0, '0, '0, 1'b0);

        checkOutput("sb_empty", sbq.size(), 32'd0);
        $display("[TB] operations accepted: %0d", n_ops);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
